// File: rtl/uart_rx_oversampled.sv
// Oversampling UART receiver with 3-sample majority voting and a valid/ready output handshake.
// Optional break detection is enabled by defining UART_RX_BREAK_EN.
module uart_rx_oversampled #(
    parameter int INPUT_DATA_WIDTH           = 8,
    parameter int PARITY_ENABLED             = 1,
    parameter int PARITY_TYPE                = 0,
    parameter int STOP_BITS                  = 1,
    parameter int CLOCKS_PER_BIT             = 16,
    parameter int NUMBER_OF_RX_SYNCHRONIZERS = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        serial_in,
    input  logic                        i_ready,
    output logic [INPUT_DATA_WIDTH-1:0] received_data,
    output logic                        data_is_valid,
    output logic                        rx_error,
    output logic                        framing_error,
    output logic                        overrun,
`ifdef UART_RX_BREAK_EN
    output logic                        o_break,
`endif
    output logic                        o_busy
);

    // state      | meaning
    // IDLE       | line idle, waiting for a falling edge
    // START      | validating the start bit at its middle
    // DATA       | shifting in data bits, LSB first
    // PARITY     | checking the parity bit
    // STOP       | checking stop bit(s); completes the frame at the last decision
    // BREAK_WAIT | break seen, waiting for the line to idle high
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK_WAIT} state_t;

    localparam int W   = INPUT_DATA_WIDTH;
    localparam int MID = CLOCKS_PER_BIT / 2;
    localparam int CW  = $clog2(CLOCKS_PER_BIT);
    localparam int BW  = 4;
    localparam logic [CW-1:0] MID_M1    = CW'(MID - 1);
    localparam logic [CW-1:0] MID_C     = CW'(MID);
    localparam logic [CW-1:0] MID_P1    = CW'(MID + 1);
    localparam logic [CW-1:0] LAST_CNT  = CW'(CLOCKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(W - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
    localparam logic          PTYPE     = (PARITY_TYPE != 0);

    logic [NUMBER_OF_RX_SYNCHRONIZERS-1:0] sync;
    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [BW-1:0]   bit_idx, bit_n;
    logic [W-1:0]    shift, shift_n;
    logic            s0, s1;
    logic            par_err, par_n;
    logic            frm_err, frm_n;
    logic            complete;
    logic            line, decide, maj;
`ifdef UART_RX_BREAK_EN
    logic            all_zero, all_zero_n;
    logic            brk;
`endif

    assign line   = sync[NUMBER_OF_RX_SYNCHRONIZERS-1];
    assign decide = (cnt == MID_P1);
    assign maj    = (s0 & s1) | (s0 & line) | (s1 & line);

    always_comb begin
        state_n  = state;
        cnt_n    = (cnt == LAST_CNT) ? '0 : cnt + CW'(1);
        bit_n    = bit_idx;
        shift_n  = shift;
        par_n    = par_err;
        frm_n    = frm_err;
        complete = 1'b0;
`ifdef UART_RX_BREAK_EN
        all_zero_n = all_zero;
        brk        = 1'b0;
`endif
        case (state)
            IDLE: begin
                cnt_n = '0;
                bit_n = '0;
                par_n = 1'b0;
                frm_n = 1'b0;
`ifdef UART_RX_BREAK_EN
                all_zero_n = 1'b1;
`endif
                if (!line) state_n = START;
            end
            START: begin
                if (decide) begin
                    if (maj) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end else begin
                        state_n = DATA;
                        bit_n   = '0;
                    end
                end
            end
            DATA: begin
                if (decide) begin
                    shift_n = {maj, shift[W-1:1]};
`ifdef UART_RX_BREAK_EN
                    if (maj) all_zero_n = 1'b0;
`endif
                    if (bit_idx == LAST_DATA) begin
                        bit_n   = '0;
                        state_n = (PARITY_ENABLED != 0) ? PARITY : STOP;
                    end else begin
                        bit_n = bit_idx + BW'(1);
                    end
                end
            end
            PARITY: begin
                if (decide) begin
                    par_n   = (^shift) ^ maj ^ PTYPE;
`ifdef UART_RX_BREAK_EN
                    if (maj) all_zero_n = 1'b0;
`endif
                    bit_n   = '0;
                    state_n = STOP;
                end
            end
            STOP: begin
                if (decide) begin
`ifdef UART_RX_BREAK_EN
                    if (bit_idx == '0 && all_zero && !maj) begin
                        brk     = 1'b1;
                        state_n = BREAK_WAIT;
                        cnt_n   = '0;
                    end else
`endif
                    begin
                        if (!maj) frm_n = 1'b1;
                        if (bit_idx == LAST_STOP) begin
                            // Return to IDLE at mid-bit so the next start edge is caught early.
                            complete = 1'b1;
                            state_n  = IDLE;
                            cnt_n    = '0;
                        end else begin
                            bit_n = bit_idx + BW'(1);
                        end
                    end
                end
            end
            BREAK_WAIT: begin
                if (!line) begin
                    cnt_n = '0;
                end else if (cnt == MID_M1) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync          <= '1;
            state         <= IDLE;
            cnt           <= '0;
            bit_idx       <= '0;
            shift         <= '0;
            s0            <= 1'b0;
            s1            <= 1'b0;
            par_err       <= 1'b0;
            frm_err       <= 1'b0;
            received_data <= '0;
            data_is_valid <= 1'b0;
            rx_error      <= 1'b0;
            framing_error <= 1'b0;
            overrun       <= 1'b0;
            o_busy        <= 1'b0;
`ifdef UART_RX_BREAK_EN
            all_zero      <= 1'b0;
            o_break       <= 1'b0;
`endif
        end else begin
            sync    <= {sync[NUMBER_OF_RX_SYNCHRONIZERS-2:0], serial_in};
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_n;
            shift   <= shift_n;
            par_err <= par_n;
            frm_err <= frm_n;
            if (cnt == MID_M1) s0 <= line;
            if (cnt == MID_C)  s1 <= line;
            overrun <= 1'b0;
            o_busy  <= (state_n != IDLE);
`ifdef UART_RX_BREAK_EN
            all_zero <= all_zero_n;
            o_break  <= brk;
`endif
            if (data_is_valid && i_ready) data_is_valid <= 1'b0;
            if (complete) begin
                if (!data_is_valid || i_ready) begin
                    received_data <= shift_n;
                    rx_error      <= par_n;
                    framing_error <= frm_n;
                    data_is_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end
        end
    end

endmodule
